serial_digit_adder: RTL and testbench
=====================================

# serial_digit_adder

Multi-cycle, parametrised ripple-carry adder/subtractor that processes a WIDTH-bit operand pair one DIGIT-bit slice per clock. It is the successor to the fixed 16-bit ripple-carry adder: same carry-chain arithmetic, generalised in width and slice size, with add/subtract mode and a start/done handshake. It is intended for datapath units that trade latency for area in the arithmetic section of the design.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  in  1  request; accepted only when busy=0.
- sub  in  1  0: a+b+cin; 1: a−b (a + ~b + 1, cin ignored).
- a  in  WIDTH  operand A, sampled only on the accepting edge.
- b  in  WIDTH  operand B, sampled only on the accepting edge.
- cin  in  1  carry-in, sampled only on the accepting edge.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- sum  out  WIDTH  result; held until the next completion.
- cout  out  1  carry-out of MSB (in subtract mode, 1 means no borrow).
- ovf  out  1  signed overflow; present only with OVERFLOW_EN (see Configuration).

## Operation
- NDIG = WIDTH/DIGIT slices, processed LSB slice first.
- States:
  - IDLE: busy=0. start → RUN. Latch a, b_eff = sub ? ~b : b, and carry = sub ? 1 : cin. Clear slice index.
  - RUN: busy=1. Each edge adds slice[idx] of a and b_eff plus the carry, using a DIGIT-bit ripple adder. Write the slice into the shadow result, register the slice carry, and increment idx. On the edge that processes slice NDIG−1 → DONE, copy the shadow result to sum and the final carry to cout, and set done=1.
  - DONE: busy=0, done=1 for exactly this cycle. start → RUN (same capture as IDLE); otherwise → IDLE.
- start while busy=1 is ignored and not queued.
- Arithmetic is modulo 2^WIDTH. The carry between slices is registered, so each cycle's combinational path is one DIGIT-bit ripple.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, idx=0, shadow result and operand registers 0.
- rst asserted mid-operation aborts the operation. Outputs take their reset values on that edge and no done is issued. rst has priority over start.

## Timing
- Accepting edge E0: busy=1 from E0.
- Slices are processed on edges E1..E_NDIG.
- sum, cout, ovf and done=1 update at E_NDIG; busy=0 from E_NDIG.
- Latency from the accepting edge to done is NDIG cycles. Back-to-back throughput is one operation per NDIG+1 cycles (start in the DONE cycle is accepted at E_NDIG+1).
- sum/cout/ovf never change except at a completion edge or reset.

## Configuration
- Macro SERIAL_ADDER_OVERFLOW_EN.
- Defined: ovf port exists. At completion, ovf = carry into MSB XOR carry out of MSB (signed overflow for add and subtract). It is registered together with sum.
- Undefined: ovf port is absent and no overflow logic is generated. All other behaviour is identical.

## Structure
- Shared package serial_adder_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - function/constant for NDIG and the idx width, $clog2(NDIG) with a minimum of 1.
- Sub-module digit_adder: combinational DIGIT-bit ripple adder (a, b, cin → sum, cout), instantiated once and reused every cycle.

## Test plan
- WIDTH=16, DIGIT=4, sub=0: a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0. done exactly 4 cycles after the accepting edge; busy high for the 4 cycles in between.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. With macro: a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1.
- sub=1: a=0x0005, b=0x0007 → sum=0xFFFE, cout=0. sub=1: a=0x0007, b=0x0005, cin=1 → sum=0x0002, cout=1 (cin ignored).
- start held high continuously:
  - pulses at E1 and E2 while busy are ignored;
  - operations complete every 5 cycles, each using the operands present on its own accepting edge.
- rst asserted at E2 of an operation → no done pulse; sum=0, busy=0 next cycle. A new start is accepted on the following edge.
- Parameter corners:
  - DIGIT=1 → 16-cycle latency;
  - DIGIT=16 → 1-cycle latency;
  - WIDTH=32, DIGIT=8 with 0xFFFFFFFF+0x00000001 → sum=0, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Brief    : Shared types and sizing helpers for the serial digit adder.
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Control state of the slice sequencer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of DIGIT-wide slices in a WIDTH-bit operand
    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Slice index width; a single-slice build still needs one index bit
    function automatic int calc_idx_w(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_digit_adder_digit_adder.sv
`default_nettype none
// ============================================================================
// Module   : digit_adder
// Brief    : Combinational DIGIT-bit ripple-carry adder (one slice).
// Revision : 1.0 - initial release
// ============================================================================
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = i_cin;

    // One full adder per bit, carry rippling upward
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_ripple
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_c[DIGIT];

endmodule : digit_adder
`default_nettype wire

// File: rtl/serial_digit_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_digit_adder
// Brief    : Multi-cycle WIDTH-bit adder/subtractor, one DIGIT-bit slice per
//            clock, LSB slice first, with start/busy/done handshake.
//            Optional signed-overflow output: define SERIAL_ADDER_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_digit_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 C_NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int                 C_IDX_W = calc_idx_w(WIDTH, DIGIT);
    localparam logic [C_IDX_W-1:0] C_LAST  = C_IDX_W'(C_NDIG - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;        // already inverted for subtract
    logic               r_carry;    // registered inter-slice carry
    logic [C_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_shadow;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [31:0]        w_off;
    logic [DIGIT-1:0]   w_da;
    logic [DIGIT-1:0]   w_db;
    logic [DIGIT-1:0]   w_dsum;
    logic               w_dcout;
    logic [WIDTH-1:0]   w_shadow_nxt;

    assign w_off = 32'(r_idx) * 32'(DIGIT);
    assign w_da  = r_a[w_off +: DIGIT];
    assign w_db  = r_b[w_off +: DIGIT];

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a    (w_da),
        .i_b    (w_db),
        .i_cin  (r_carry),
        .o_sum  (w_dsum),
        .o_cout (w_dcout)
    );

    // Merge the current slice into the partial result
    always_comb begin
        w_shadow_nxt                 = r_shadow;
        w_shadow_nxt[w_off +: DIGIT] = w_dsum;
    end

    assign w_last = (r_state == ST_RUN) && (r_idx == C_LAST);

    // Next-state decode; a new request is only taken while not running
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_idx == C_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, slice sequencing and result registration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_shadow <= w_shadow_nxt;
            r_carry  <= w_dcout;
            r_idx    <= w_last ? '0 : r_idx + C_IDX_W'(1);
            if (w_last) begin
                r_sum  <= w_shadow_nxt;
                r_cout <= w_dcout;
            end
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic r_ovf;
    logic w_msb_cin;

    // Carry into the MSB recovered from the top bit's sum equation
    assign w_msb_cin = w_dsum[DIGIT-1] ^ w_da[DIGIT-1] ^ w_db[DIGIT-1];

    // Signed overflow, registered alongside the sum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (!w_accept && w_last) begin
            r_ovf <= w_msb_cin ^ w_dcout;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : serial_digit_adder
`default_nettype wire

// File: tb/tb_serial_digit_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_digit_adder
// Brief    : Self-checking bench for serial_digit_adder (16/4 main instance,
//            plus 16/1, 16/16 and 32/8 parameter corners). Overflow checks
//            are compiled in when SERIAL_ADDER_OVERFLOW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_digit_adder;

    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        rst, start, sub, cin;
    logic [15:0] a, b;
    logic [31:0] a32, b32;

    logic        busy, done, cout;
    logic [15:0] sum;
    logic        busy1, done1, cout1;
    logic [15:0] sum1;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic        ovf, ovf1, ovf16, ovf32;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    serial_digit_adder #(.WIDTH(16), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );

    serial_digit_adder #(.WIDTH(16), .DIGIT(16)) dut_d16 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .ovf(ovf16)
`endif
    );

    serial_digit_adder #(.WIDTH(32), .DIGIT(8)) dut_w32 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a32), .b(b32), .cin(cin),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .ovf(ovf32)
`endif
    );

    // Reference: plain modular arithmetic and sign rules
    function automatic void model(input longint unsigned x, input longint unsigned y,
                                  input bit s, input bit ci, input int w,
                                  output longint unsigned r, output bit co, output bit ov);
        longint unsigned m, t;
        m = (64'd1 << w) - 64'd1;
        if (s) begin
            t  = (x - y) & m;
            co = (x >= y);
        end else begin
            t  = x + y + 64'(ci);
            co = ((t >> w) != 0);
            t  = t & m;
        end
        r = t;
        if (s) ov = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
        else   ov = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0;
        a = '0; b = '0; a32 = '0; b32 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, cout, sum} !== 19'd0) $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
        else n_pass++;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        n_checks++;
        if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
        else n_pass++;
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One operation from idle; checks handshake timing and the result
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input bit ts, input bit tc);
        longint unsigned er;
        bit eco, eov;
        model(64'(ta), 64'(tb_), ts, tc, 16, er, eco, eov);
        @(negedge clk);
        a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL accept_busy: got busy=%b done=%b want 1/0", busy, done);
        else n_pass++;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        for (int k = 1; k <= NDIG; k++) begin
            @(posedge clk); #1;
            if (k < NDIG) begin
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0) $display("FAIL run_busy k=%0d: got busy=%b done=%b want 1/0", k, busy, done);
                else n_pass++;
            end else begin
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0) $display("FAIL done_pulse: got busy=%b done=%b want 0/1", busy, done);
                else n_pass++;
                n_checks++;
                if (sum !== er[15:0] || cout !== eco)
                    $display("FAIL result %h %s %h cin=%b: got sum=%h cout=%b want sum=%h cout=%b", ta, ts ? "-" : "+", tb_, tc, sum, cout, er[15:0], eco);
                else n_pass++;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                n_checks++;
                if (ovf !== eov) $display("FAIL ovf %h %s %h: got %b want %b", ta, ts ? "-" : "+", tb_, ovf, eov);
                else n_pass++;
`endif
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || sum !== er[15:0]) $display("FAIL after_done: got done=%b sum=%h want 0/%h", done, sum, er[15:0]);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // start held high: accepts every NDIG+1 cycles, each with its own operands
    task automatic test_back_to_back();
        logic [15:0] oa [0:19];
        logic [15:0] ob [0:19];
        bit          os [0:19];
        bit          oc [0:19];
        longint unsigned er;
        bit eco, eov;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            oa[c] = 16'($urandom); ob[c] = 16'($urandom); os[c] = 1'($urandom); oc[c] = 1'($urandom);
            a = oa[c]; b = ob[c]; sub = os[c]; cin = oc[c]; start = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (busy !== ((c % 5) != 4)) $display("FAIL b2b_busy c=%0d: got %b want %b", c, busy, ((c % 5) != 4));
            else n_pass++;
            n_checks++;
            if (done !== ((c % 5) == 4)) $display("FAIL b2b_done c=%0d: got %b want %b", c, done, ((c % 5) == 4));
            else n_pass++;
            if ((c % 5) == 4) begin
                model(64'(oa[c-4]), 64'(ob[c-4]), os[c-4], oc[c-4], 16, er, eco, eov);
                n_checks++;
                if (sum !== er[15:0] || cout !== eco) $display("FAIL b2b_result c=%0d: got %h/%b want %h/%b", c, sum, cout, er[15:0], eco);
                else n_pass++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Reset at the second slice edge aborts; next start is taken right after
    task automatic test_reset_abort();
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0 || cout !== 1'b0)
            $display("FAIL abort_state: got busy=%b done=%b sum=%h cout=%b want 0/0/0000/0", busy, done, sum, cout);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; a = 16'h00FF; b = 16'h0F01; start = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL abort_restart: got busy=%b want 1", busy);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= NDIG; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== (k == NDIG)) $display("FAIL abort_done k=%0d: got %b want %b", k, done, (k == NDIG));
            else n_pass++;
        end
        n_checks++;
        if (sum !== 16'h1000) $display("FAIL abort_result: got %h want 1000", sum);
        else n_pass++;
        @(posedge clk);
    endtask

    task automatic test_param_corners();
        int lat1, lat16, lat32;
        longint unsigned er;
        bit eco, eov;
        lat1 = -1; lat16 = -1; lat32 = -1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        a = 16'hA5C3; b = 16'h7B1E; a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001;
        sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done1  === 1'b1 && lat1  < 0) lat1  = k;
            if (done16 === 1'b1 && lat16 < 0) lat16 = k;
            if (done32 === 1'b1 && lat32 < 0) lat32 = k;
        end
        model(64'h A5C3, 64'h7B1E, 1'b0, 1'b0, 16, er, eco, eov);
        n_checks++;
        if (lat1 != 16) $display("FAIL lat_digit1: got %0d want 16", lat1);
        else n_pass++;
        n_checks++;
        if (lat16 != 1) $display("FAIL lat_digit16: got %0d want 1", lat16);
        else n_pass++;
        n_checks++;
        if (lat32 != 4) $display("FAIL lat_w32: got %0d want 4", lat32);
        else n_pass++;
        n_checks++;
        if (sum1 !== er[15:0] || cout1 !== eco) $display("FAIL res_digit1: got %h/%b want %h/%b", sum1, cout1, er[15:0], eco);
        else n_pass++;
        n_checks++;
        if (sum16 !== er[15:0] || cout16 !== eco) $display("FAIL res_digit16: got %h/%b want %h/%b", sum16, cout16, er[15:0], eco);
        else n_pass++;
        n_checks++;
        if (sum32 !== 32'h0 || cout32 !== 1'b1) $display("FAIL res_w32: got %h/%b want 00000000/1", sum32, cout32);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_param_corners();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_digit_adder
`default_nettype wire
